// File: rtl/sseg_scanner.sv
// rtl/sseg_scanner.sv - multiplexed seven-segment scanner with double buffering, guard interval and PWM dimming
module sseg_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 100000,
    parameter int GUARD      = 64,
    parameter int BRIGHT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   sseg_sel,
    output logic [7:0]              sseg_sig,
    output logic                    frame_tick
);

    // Counter widths never collapse to zero so single-digit builds still elaborate.
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] GUARD_V  = PRE_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Scan position and PWM phase.
    logic [PRE_W-1:0]    pre_cnt;
    logic [IDX_W-1:0]    idx;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic [BRIGHT_W-1:0] bright_q;

    // Pending buffer (written by load) and active buffer (what is on the glass).
    logic [4*NUM_DIGITS-1:0] dig_pend;
    logic [NUM_DIGITS-1:0]   dp_pend;
    logic [NUM_DIGITS-1:0]   en_pend;
    logic                    pend;
    logic [4*NUM_DIGITS-1:0] dig_act;
    logic [NUM_DIGITS-1:0]   dp_act;
    logic [NUM_DIGITS-1:0]   en_act;

    // Combinational view of the current slot.
    logic                  pre_wrap;
    logic                  frame_wrap;
    logic [3:0]            cur_dig;
    logic                  cur_dp;
    logic                  cur_en;
    logic                  duty_on;
    logic                  lit;
    logic [NUM_DIGITS-1:0] sel_next;
    logic [7:0]            sig_next;

    // Hex nibble to active-high gfedcba pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Slot and frame boundary detection.
    always_comb begin
        pre_wrap   = (pre_cnt == PRE_LAST);
        frame_wrap = pre_wrap && (idx == IDX_LAST);
    end

    // Prescaler and digit index: idx steps once per slot and wraps after the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            idx     <= '0;
        end else if (pre_wrap) begin
            pre_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Free-running PWM phase and a plain one-cycle brightness sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt  <= '0;
            bright_q <= '0;
        end else begin
            pwm_cnt  <= pwm_cnt + BRIGHT_W'(1);
            bright_q <= brightness;
        end
    end

    // Pending buffer: every load overwrites it, so the last load before a frame wrap wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_pend <= '0;
            dp_pend  <= '0;
            en_pend  <= '0;
        end else if (load) begin
            dig_pend <= digits;
            dp_pend  <= dp;
            en_pend  <= digit_en;
        end
    end

    // Commit at frame wrap only; a load landing on the wrap cycle bypasses the pending stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_act <= '0;
            dp_act  <= '0;
            en_act  <= '0;
            pend    <= 1'b0;
        end else if (frame_wrap && load) begin
            dig_act <= digits;
            dp_act  <= dp;
            en_act  <= digit_en;
            pend    <= 1'b0;
        end else if (frame_wrap && pend) begin
            dig_act <= dig_pend;
            dp_act  <= dp_pend;
            en_act  <= en_pend;
            pend    <= 1'b0;
        end else if (load) begin
            pend    <= 1'b1;
        end
    end

    // Pick the active digit, decimal point and enable for the slot being scanned.
    always_comb begin
        cur_dig = '0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_dig = dig_act[4*i +: 4];
                cur_dp  = dp_act[i];
                cur_en  = en_act[i];
            end
        end
    end

    // Lit decision: past the guard interval, digit enabled, and inside the PWM on-window.
    always_comb begin
        duty_on = (&bright_q) || ((|bright_q) && (pwm_cnt < bright_q));
        lit     = (pre_cnt >= GUARD_V) && cur_en && duty_on;
    end

    // Active-low anode and segment values for the next cycle.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_next[i] = !(lit && (idx == IDX_W'(i)));
        end
        sig_next = lit ? ~{cur_dp, hex_to_seg(cur_dig)} : 8'hFF;
    end

    // Output registers: one cycle behind the scan state, blank on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sseg_sel   <= '1;
            sseg_sig   <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            sseg_sel   <= sel_next;
            sseg_sig   <= sig_next;
            frame_tick <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_sseg_scanner.sv
// tb/tb_sseg_scanner.sv - self-checking bench for sseg_scanner
module tb_sseg_scanner;

    localparam int N  = 4;
    localparam int P  = 32;
    localparam int G  = 2;
    localparam int BW = 2;
    localparam int FR = N * P;

    logic          clk;
    logic          rst_n;
    logic [15:0]   digits;
    logic [3:0]    dp;
    logic [3:0]    digit_en;
    logic          load;
    logic [1:0]    brightness;
    logic [3:0]    sseg_sel;
    logic [7:0]    sseg_sig;
    logic          frame_tick;

    int checks = 0;
    int passed = 0;

    sseg_scanner #(
        .NUM_DIGITS (N),
        .PRESCALE   (P),
        .GUARD      (G),
        .BRIGHT_W   (BW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits     (digits),
        .dp         (dp),
        .digit_en   (digit_en),
        .load       (load),
        .brightness (brightness),
        .sseg_sel   (sseg_sel),
        .sseg_sig   (sseg_sig),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] h);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[h];
    endfunction

    // Reference model: scan state derived arithmetically from the cycle count since reset.
    int         mn;
    logic [15:0] m_pdig, m_adig;
    logic [3:0]  m_pdp, m_adp, m_pen, m_aen;
    logic        m_pend;
    logic [1:0]  m_bright;
    logic [3:0]  exp_sel;
    logic [7:0]  exp_sig;
    logic        exp_tick;

    always @(posedge clk or negedge rst_n) begin
        int   pre, id, pw;
        logic lit;
        if (!rst_n) begin
            mn = 0; m_pdig = '0; m_adig = '0; m_pdp = '0; m_adp = '0;
            m_pen = '0; m_aen = '0; m_pend = 1'b0; m_bright = '0;
            exp_sel = 4'hF; exp_sig = 8'hFF; exp_tick = 1'b0;
        end else begin
            pre = mn % P;
            id  = (mn / P) % N;
            pw  = mn % (1 << BW);
            lit = (pre >= G) && m_aen[id] &&
                  ((m_bright == 2'b11) || (m_bright != 2'b00 && pw < int'(m_bright)));
            exp_sel = 4'hF;
            if (lit) exp_sel[id] = 1'b0;
            exp_sig  = lit ? ~{m_adp[id], ref_seg(m_adig[id*4 +: 4])} : 8'hFF;
            exp_tick = ((mn % FR) == FR - 1);
            if (exp_tick && load) begin
                m_adig = digits; m_adp = dp; m_aen = digit_en; m_pend = 1'b0;
            end else begin
                if (exp_tick && m_pend) begin
                    m_adig = m_pdig; m_adp = m_pdp; m_aen = m_pen; m_pend = 1'b0;
                end
                if (load) begin
                    m_pdig = digits; m_pdp = dp; m_pen = digit_en; m_pend = 1'b1;
                end
            end
            m_bright = brightness;
            mn++;
        end
    end

    task automatic test_reset();
        int ticks, first, second;
        rst_n = 1'b0; digits = '0; dp = '0; digit_en = '0; load = 1'b0; brightness = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (sseg_sel !== 4'hF || sseg_sig !== 8'hFF || frame_tick !== 1'b0)
            $display("FAIL reset_hold sel=%h sig=%h tick=%b want F/FF/0", sseg_sel, sseg_sig, frame_tick);
        else passed++;
        #2 rst_n = 1'b1;
        ticks = 0; first = -1; second = -1;
        for (int c = 1; c <= 256; c++) begin
            @(negedge clk);
            checks++;
            if (sseg_sel !== exp_sel || sseg_sig !== exp_sig || frame_tick !== exp_tick)
                $display("FAIL idle_model cyc=%0d sel=%h/%h sig=%h/%h tick=%b/%b", mn, sseg_sel, exp_sel, sseg_sig, exp_sig, frame_tick, exp_tick);
            else passed++;
            checks++;
            if (sseg_sel !== 4'hF || sseg_sig !== 8'hFF)
                $display("FAIL idle_blank cyc=%0d sel=%h sig=%h want F/FF", c, sseg_sel, sseg_sig);
            else passed++;
            if (frame_tick === 1'b1) begin
                ticks++;
                if (first < 0) first = c; else second = c;
            end
        end
        checks++;
        if (ticks != 2 || second - first != FR)
            $display("FAIL tick_period ticks=%0d gap=%0d want 2/%0d", ticks, second - first, FR);
        else passed++;
    endtask

    task automatic test_slots();
        logic [3:0] sel_tab [4];
        logic [7:0] sig_tab [4];
        int k;
        sel_tab = '{4'hE, 4'hD, 4'hB, 4'h7};
        sig_tab = '{~8'h71, ~8'h4F, ~8'hF7, ~8'h06};
        digits = 16'h1A3F; dp = 4'b0100; digit_en = 4'hF; brightness = 2'd3; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            checks++;
            if (sseg_sel !== exp_sel || sseg_sig !== exp_sig || frame_tick !== exp_tick)
                $display("FAIL slots_wait cyc=%0d sel=%h/%h sig=%h/%h tick=%b/%b", mn, sseg_sel, exp_sel, sseg_sig, exp_sig, frame_tick, exp_tick);
            else passed++;
        end while (frame_tick !== 1'b1 && k < 400);
        checks++;
        if (frame_tick !== 1'b1) $display("FAIL slots_tick_timeout tick=%b want 1", frame_tick);
        else passed++;
        for (int j = 0; j < FR; j++) begin
            logic [3:0] es;
            logic [7:0] eg;
            @(negedge clk);
            es = ((j % P) < G) ? 4'hF  : sel_tab[j / P];
            eg = ((j % P) < G) ? 8'hFF : sig_tab[j / P];
            checks++;
            if (sseg_sel !== es || sseg_sig !== eg)
                $display("FAIL slot_pattern j=%0d sel=%h want %h sig=%h want %h", j, sseg_sel, es, sseg_sig, eg);
            else passed++;
        end
    endtask

    task automatic test_midframe_load();
        int k, old_seen;
        k = 0;
        while (!(((mn / P) % N) == 1 && (mn % P) == 5) && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 300) $display("FAIL mid_slot1_timeout waited=%0d want <300", k);
        else passed++;
        digits = 16'h0000; dp = 4'b0000; digit_en = 4'hF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        k = 0; old_seen = 0;
        do begin
            @(negedge clk);
            k++;
            checks++;
            if (sseg_sel !== exp_sel || sseg_sig !== exp_sig || frame_tick !== exp_tick)
                $display("FAIL mid_model cyc=%0d sel=%h/%h sig=%h/%h tick=%b/%b", mn, sseg_sel, exp_sel, sseg_sig, exp_sig, frame_tick, exp_tick);
            else passed++;
            if (sseg_sel === 4'h7) begin
                old_seen++;
                checks++;
                if (sseg_sig !== ~8'h06) $display("FAIL mid_old_kept sig=%h want %h", sseg_sig, ~8'h06);
                else passed++;
            end
        end while (frame_tick !== 1'b1 && k < 200);
        checks++;
        if (old_seen != P - G) $display("FAIL mid_old_count seen=%0d want %0d", old_seen, P - G);
        else passed++;
        repeat (5) @(negedge clk);
        checks++;
        if (sseg_sel !== 4'hE || sseg_sig !== ~8'h3F)
            $display("FAIL mid_new_frame sel=%h sig=%h want E/%h", sseg_sel, sseg_sig, ~8'h3F);
        else passed++;
    endtask

    task automatic test_brightness();
        int want [4];
        want = '{0, 28, 56, 120};
        for (int b = 0; b < 4; b++) begin
            int cnt;
            brightness = 2'(b);
            repeat (4) @(negedge clk);
            cnt = 0;
            for (int c = 0; c < FR; c++) begin
                @(negedge clk);
                checks++;
                if (sseg_sel !== exp_sel || sseg_sig !== exp_sig || frame_tick !== exp_tick)
                    $display("FAIL bright_model b=%0d cyc=%0d sel=%h/%h sig=%h/%h", b, mn, sseg_sel, exp_sel, sseg_sig, exp_sig);
                else passed++;
                if (sseg_sel !== 4'hF) cnt++;
            end
            checks++;
            if (cnt != want[b]) $display("FAIL bright_duty b=%0d lit=%0d want %0d", b, cnt, want[b]);
            else passed++;
        end
    endtask

    task automatic test_digit_en();
        int k, cnt;
        digits = 16'($urandom); dp = 4'($urandom); digit_en = 4'b1010; brightness = 2'd3; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (frame_tick !== 1'b1 && k < 200);
        checks++;
        if (frame_tick !== 1'b1) $display("FAIL en_tick_timeout tick=%b want 1", frame_tick);
        else passed++;
        cnt = 0;
        for (int c = 0; c < FR; c++) begin
            @(negedge clk);
            checks++;
            if (sseg_sel !== exp_sel || sseg_sig !== exp_sig || frame_tick !== exp_tick)
                $display("FAIL en_model cyc=%0d sel=%h/%h sig=%h/%h", mn, sseg_sel, exp_sel, sseg_sig, exp_sig);
            else passed++;
            checks++;
            if (sseg_sel[0] !== 1'b1 || sseg_sel[2] !== 1'b1)
                $display("FAIL en_masked cyc=%0d sel=%h want bits0,2 high", mn, sseg_sel);
            else passed++;
            if (sseg_sel !== 4'hF) cnt++;
        end
        checks++;
        if (cnt != 2 * (P - G)) $display("FAIL en_lit_count lit=%0d want %0d", cnt, 2 * (P - G));
        else passed++;
    endtask

    task automatic test_wrap_load();
        int k;
        k = 0;
        while ((mn % FR) != FR - 1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 300) $display("FAIL wrap_wait_timeout waited=%0d want <300", k);
        else passed++;
        digits = 16'h00B7; dp = 4'b0000; digit_en = 4'hF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (sseg_sel !== exp_sel || sseg_sig !== exp_sig || frame_tick !== exp_tick)
                $display("FAIL wrap_model cyc=%0d sel=%h/%h sig=%h/%h", mn, sseg_sel, exp_sel, sseg_sig, exp_sig);
            else passed++;
        end
        checks++;
        if (sseg_sel !== 4'hE || sseg_sig !== ~8'h07)
            $display("FAIL wrap_immediate sel=%h sig=%h want E/%h", sseg_sel, sseg_sig, ~8'h07);
        else passed++;
        for (int c = 0; c < FR + 8; c++) begin
            @(negedge clk);
            checks++;
            if (sseg_sel !== exp_sel || sseg_sig !== exp_sig || frame_tick !== exp_tick)
                $display("FAIL wrap_after cyc=%0d sel=%h/%h sig=%h/%h", mn, sseg_sel, exp_sel, sseg_sig, exp_sig);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int k, tick_at;
        k = 0;
        while (!(((mn / P) % N) == 2 && (mn % P) == 10) && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 300 || sseg_sel !== 4'hB) $display("FAIL rstmid_setup waited=%0d sel=%h want B", k, sseg_sel);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (sseg_sel !== 4'hF || sseg_sig !== 8'hFF || frame_tick !== 1'b0)
            $display("FAIL rstmid_async sel=%h sig=%h tick=%b want F/FF/0", sseg_sel, sseg_sig, frame_tick);
        else passed++;
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick_at = -1;
        for (int c = 1; c <= FR + 12; c++) begin
            @(negedge clk);
            checks++;
            if (sseg_sel !== exp_sel || sseg_sig !== exp_sig || frame_tick !== exp_tick)
                $display("FAIL rstmid_model cyc=%0d sel=%h/%h sig=%h/%h tick=%b/%b", mn, sseg_sel, exp_sel, sseg_sig, exp_sig, frame_tick, exp_tick);
            else passed++;
            checks++;
            if (sseg_sel !== 4'hF) $display("FAIL rstmid_discard c=%0d sel=%h want F", c, sseg_sel);
            else passed++;
            if (frame_tick === 1'b1 && tick_at < 0) tick_at = c;
        end
        checks++;
        if (tick_at != FR) $display("FAIL rstmid_restart tick_at=%0d want %0d", tick_at, FR);
        else passed++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 39) == 0) begin
                digits = 16'($urandom); dp = 4'($urandom); digit_en = 4'($urandom); load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 199) == 0) brightness = 2'($urandom);
            @(negedge clk);
            checks++;
            if (sseg_sel !== exp_sel || sseg_sig !== exp_sig || frame_tick !== exp_tick)
                $display("FAIL random_model cyc=%0d sel=%h/%h sig=%h/%h tick=%b/%b", mn, sseg_sel, exp_sel, sseg_sig, exp_sig, frame_tick, exp_tick);
            else passed++;
        end
        load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_slots();
        test_midframe_load();
        test_brightness();
        test_digit_en();
        test_wrap_load();
        test_reset_mid();
        brightness = 2'd3;
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
